// File: rtl/servo_pkg.sv
// Shared definitions for the ramped servo controller.
//   estado_t        : FSM state encoding, also exported on db_estado
//   largura_indice  : bit width needed to index an n-entry table (minimum 1)
//   entrada_tabela  : extracts entry idx of a packed table of larg_w-bit entries
package servo_pkg;

  typedef enum logic [1:0] {
    REPOUSO    = 2'd0,
    MOVENDO    = 2'd1,
    ASSENTANDO = 2'd2,
    FIM        = 2'd3
  } estado_t;

  // Packed tables wider than TAB_MAX_W or entries wider than ENT_MAX_W are not supported.
  localparam int unsigned TAB_MAX_W = 256;
  localparam int unsigned ENT_MAX_W = 32;

  function automatic int unsigned largura_indice(input int unsigned n);
    return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
  endfunction

  function automatic logic [ENT_MAX_W-1:0] entrada_tabela(
    input logic [TAB_MAX_W-1:0] tabela,
    input int unsigned          idx,
    input int unsigned          larg_w
  );
    logic [TAB_MAX_W-1:0] desloc;
    logic [ENT_MAX_W-1:0] mascara;
    desloc  = tabela >> (idx * larg_w);
    mascara = (larg_w >= ENT_MAX_W) ? '1 : ((ENT_MAX_W'(1) << larg_w) - ENT_MAX_W'(1));
    return desloc[ENT_MAX_W-1:0] & mascara;
  endfunction

endpackage

// File: rtl/controle_servo_rampa_if.sv
// Move-request handshake between the sequencer (master) and the servo controller (slave).
//   iniciar : move request, honoured only while the controller is idle
//   posicao : target position-table index
//   ocupado : move in progress
//   pronto  : one-cycle completion pulse
interface controle_servo_rampa_if
  import servo_pkg::*;
#(
  parameter int unsigned N_POS = 4
) ();

  localparam int unsigned POS_W = largura_indice(N_POS);

  logic             iniciar;
  logic [POS_W-1:0] posicao;
  logic             ocupado;
  logic             pronto;

  modport master (output iniciar, output posicao, input ocupado, input pronto);
  modport slave  (input iniciar, input posicao, output ocupado, output pronto);

endinterface

// File: rtl/gerador_pwm_periodo.sv
// Fixed-period PWM generator.
//   clock, reset  : system clock, asynchronous active-low reset
//   largura_i     : pulse width in clocks; the owner only changes it on the fim_periodo_c edge,
//                   so each new width takes effect from counter 0 of the next period
//   pwm_o         : registered pwm, one cycle behind the counter compare
//   fim_periodo_c : combinational strobe on the last cycle of each period
module gerador_pwm_periodo #(
  parameter int unsigned PERIODO = 1000000,
  parameter int unsigned LARG_W  = 20
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [LARG_W-1:0] largura_i,
  output logic              pwm_o,
  output logic              fim_periodo_c
);

  localparam logic [LARG_W-1:0] ULTIMO = LARG_W'(PERIODO - 1);

  logic [LARG_W-1:0] contador_q;
  logic              pwm_q;

  assign fim_periodo_c = (contador_q == ULTIMO);
  assign pwm_o         = pwm_q;

  // Period counter and registered width compare
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      contador_q <= '0;
      pwm_q      <= 1'b0;
    end else begin
      contador_q <= fim_periodo_c ? '0 : contador_q + LARG_W'(1);
      pwm_q      <= (contador_q < largura_i);
    end
  end

endmodule

// File: rtl/controle_servo_rampa.sv
// Servo PWM controller that slews toward a table-selected width and reports completion.
//   clock, reset : system clock, asynchronous active-low reset
//   cmd          : iniciar/posicao request in, ocupado/pronto status out
//   pwm          : servo control signal
//   db_estado    : current FSM state encoding
//   db_largura   : width currently applied to the PWM generator
module controle_servo_rampa
  import servo_pkg::*;
#(
  parameter int unsigned               PERIODO     = 1000000,
  parameter int unsigned               N_POS       = 4,
  parameter int unsigned               LARG_W      = 20,
  parameter logic [N_POS*LARG_W-1:0]   LARGURAS    = {20'd114300, 20'd68300, 20'd48000, 20'd28000},
  parameter int unsigned               POS_INICIAL = 1,
  parameter int unsigned               PASSO       = 2000,
  parameter int unsigned               ESPERA      = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  controle_servo_rampa_if.slave  cmd,
  output logic                   pwm,
  output logic [1:0]             db_estado,
  output logic [LARG_W-1:0]      db_largura
);

  localparam int unsigned       POS_W        = largura_indice(N_POS);
  localparam int unsigned       ESP_W        = largura_indice(ESPERA + 1);
  localparam logic [LARG_W-1:0] LARG_INICIAL = LARG_W'(entrada_tabela(TAB_MAX_W'(LARGURAS), POS_INICIAL, LARG_W));
  localparam logic [LARG_W-1:0] PASSO_W      = LARG_W'(PASSO);
  localparam logic [LARG_W:0]   PASSO_X      = (LARG_W+1)'(PASSO);

  estado_t           estado_q;
  logic [LARG_W-1:0] largura_q;
  logic [LARG_W-1:0] alvo_q;
  logic [ESP_W-1:0]  espera_q;
  logic              ocupado_q;
  logic              pronto_q;

  logic              fim_periodo_c;
  logic [POS_W-1:0]  idx_c;
  logic              sobe_c;
  logic [LARG_W:0]   dif_c;
  logic              chega_c;
  logic [LARG_W-1:0] tabela [N_POS];

  // Position table unpacked once at elaboration
  for (genvar i = 0; i < N_POS; i++) begin : g_tabela
    assign tabela[i] = LARG_W'(entrada_tabela(TAB_MAX_W'(LARGURAS), i, LARG_W));
  end

  // Out-of-range indices select the last entry
  always_comb begin
    idx_c = POS_W'(cmd.posicao);
    if (32'(cmd.posicao) >= N_POS) idx_c = POS_W'(N_POS - 1);
  end

  // Distance to target in one extra bit so the subtraction never wraps
  assign sobe_c  = (alvo_q > largura_q);
  assign dif_c   = sobe_c ? ({1'b0, alvo_q} - {1'b0, largura_q})
                          : ({1'b0, largura_q} - {1'b0, alvo_q});
  assign chega_c = (dif_c <= PASSO_X);

  gerador_pwm_periodo #(
    .PERIODO (PERIODO),
    .LARG_W  (LARG_W)
  ) u_gerador (
    .clock         (clock),
    .reset         (reset),
    .largura_i     (largura_q),
    .pwm_o         (pwm),
    .fim_periodo_c (fim_periodo_c)
  );

  // Ramp FSM; ocupado/pronto are registered alongside the state transitions
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q  <= REPOUSO;
      largura_q <= LARG_INICIAL;
      alvo_q    <= LARG_INICIAL;
      espera_q  <= '0;
      ocupado_q <= 1'b0;
      pronto_q  <= 1'b0;
    end else begin
      pronto_q <= 1'b0;
      case (estado_q)
        REPOUSO: begin
          if (cmd.iniciar) begin
            alvo_q    <= tabela[idx_c];
            ocupado_q <= 1'b1;
            estado_q  <= MOVENDO;
          end
        end
        MOVENDO: begin
          if (fim_periodo_c) begin
            if (chega_c) begin
              largura_q <= alvo_q;
              espera_q  <= '0;
              estado_q  <= ASSENTANDO;
            end else if (sobe_c) begin
              largura_q <= largura_q + PASSO_W;
            end else begin
              largura_q <= largura_q - PASSO_W;
            end
          end
        end
        ASSENTANDO: begin
          if (espera_q == ESP_W'(ESPERA)) begin
            pronto_q <= 1'b1;
            estado_q <= FIM;
          end else if (fim_periodo_c) begin
            espera_q <= espera_q + ESP_W'(1);
          end
        end
        FIM: begin
          ocupado_q <= 1'b0;
          estado_q  <= REPOUSO;
        end
        default: estado_q <= REPOUSO;
      endcase
    end
  end

  assign cmd.ocupado = ocupado_q;
  assign cmd.pronto  = pronto_q;
  assign db_estado   = estado_q;
  assign db_largura  = largura_q;

endmodule

// File: tb/tb_controle_servo_rampa.sv
// Self-checking bench for controle_servo_rampa with a small table of move requests.
module tb_controle_servo_rampa;

  localparam int unsigned PERIODO = 100;
  localparam int unsigned N_POS   = 3;
  localparam int unsigned LARG_W  = 8;
  localparam int unsigned POS_W   = 2;
  localparam logic [N_POS*LARG_W-1:0] LARGURAS = {8'd90, 8'd50, 8'd20};
  localparam int PASSO_I    = 10;
  localparam int LARG_REPOU = 50;
  localparam int LATENCIA   = 201;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              pwm;
  logic [1:0]        db_estado;
  logic [LARG_W-1:0] db_largura;

  controle_servo_rampa_if #(.N_POS(N_POS)) cmd ();

  controle_servo_rampa #(
    .PERIODO     (PERIODO),
    .N_POS       (N_POS),
    .LARG_W      (LARG_W),
    .LARGURAS    (LARGURAS),
    .POS_INICIAL (1),
    .PASSO       (10),
    .ESPERA      (2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd        (cmd),
    .pwm        (pwm),
    .db_estado  (db_estado),
    .db_largura (db_largura)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int posicao;
    int alvo;
    int passos;
    bit repulsar;
  } mov_t;

  mov_t movs [5];

  task automatic verificar(input string nome, input int atual, input int esperado);
    n_cmp++;
    if (atual != esperado) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nome, atual, esperado);
    end
  endtask

  function automatic int proximo(input int atual, input int alvo);
    if (alvo >= atual) return (alvo - atual <= PASSO_I) ? alvo : atual + PASSO_I;
    return (atual - alvo <= PASSO_I) ? alvo : atual - PASSO_I;
  endfunction

  task automatic executar(input mov_t m, input int id);
    int  anterior, passos, prontos, ultima, amostra_pronto, ocup_baixo;
    bit  visto;
    anterior = int'(db_largura);
    passos = 0; prontos = 0; ultima = 0; amostra_pronto = 0; ocup_baixo = 0; visto = 1'b0;
    @(negedge clock);
    cmd.iniciar = 1'b1;
    cmd.posicao = POS_W'(m.posicao);
    @(negedge clock);
    cmd.iniciar = 1'b0;
    verificar($sformatf("mov%0d ocupado_sobe", id), int'(cmd.ocupado), 1);
    for (int c = 1; c <= 3000; c++) begin
      if (visto && c > amostra_pronto + 250) break;
      @(negedge clock);
      if (m.repulsar && c == 300) begin
        cmd.iniciar = 1'b1;
        cmd.posicao = POS_W'((m.posicao + 2) % 3);
      end else if (c == 301) begin
        cmd.iniciar = 1'b0;
      end
      if (int'(db_largura) != anterior) begin
        verificar($sformatf("mov%0d passo%0d", id, passos + 1), int'(db_largura), proximo(anterior, m.alvo));
        passos++;
        anterior = int'(db_largura);
        ultima = c;
      end
      if (!visto && cmd.ocupado !== 1'b1) ocup_baixo++;
      if (cmd.pronto === 1'b1) begin
        prontos++;
        if (!visto) begin
          visto = 1'b1;
          amostra_pronto = c;
        end
      end
      if (visto && c == amostra_pronto + 1)
        verificar($sformatf("mov%0d ocupado_desce", id), int'(cmd.ocupado), 0);
    end
    verificar($sformatf("mov%0d pronto_visto", id), int'(visto), 1);
    verificar($sformatf("mov%0d n_passos", id), passos, m.passos);
    verificar($sformatf("mov%0d largura_final", id), int'(db_largura), m.alvo);
    verificar($sformatf("mov%0d n_prontos", id), prontos, 1);
    verificar($sformatf("mov%0d ocupado_mantido", id), ocup_baixo, 0);
    verificar($sformatf("mov%0d estado_final", id), int'(db_estado), 0);
    if (m.passos > 0)
      verificar($sformatf("mov%0d latencia_pronto", id), amostra_pronto - ultima, LATENCIA);
  endtask

  initial begin
    int altos, ocup;
    bit achou;

    movs[0] = '{posicao: 2, alvo: 90, passos: 4, repulsar: 1'b0};
    movs[1] = '{posicao: 0, alvo: 20, passos: 7, repulsar: 1'b1};
    movs[2] = '{posicao: 3, alvo: 90, passos: 7, repulsar: 1'b0};
    movs[3] = '{posicao: 1, alvo: 50, passos: 4, repulsar: 1'b0};
    movs[4] = '{posicao: 1, alvo: 50, passos: 0, repulsar: 1'b0};

    cmd.iniciar = 1'b0;
    cmd.posicao = '0;
    #2 reset = 1'b0;
    repeat (3) @(negedge clock);
    verificar("reset pwm", int'(pwm), 0);
    verificar("reset ocupado", int'(cmd.ocupado), 0);
    verificar("reset pronto", int'(cmd.pronto), 0);
    verificar("reset estado", int'(db_estado), 0);
    verificar("reset largura", int'(db_largura), LARG_REPOU);
    reset = 1'b1;

    // Idle: pwm duty and no activity
    repeat (2) @(negedge clock);
    altos = 0; ocup = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clock);
      if (pwm === 1'b1) altos++;
      if (cmd.ocupado !== 1'b0) ocup++;
    end
    verificar("ocioso pwm_altos_300", altos, 150);
    verificar("ocioso ocupado", ocup, 0);
    verificar("ocioso largura", int'(db_largura), LARG_REPOU);

    for (int i = 0; i < 5; i++) executar(movs[i], i);

    // Reset during a ramp from 50 toward 90
    @(negedge clock);
    cmd.iniciar = 1'b1;
    cmd.posicao = POS_W'(2);
    @(negedge clock);
    cmd.iniciar = 1'b0;
    achou = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (int'(db_largura) == 70) begin
        achou = 1'b1;
        break;
      end
      @(negedge clock);
    end
    verificar("rampa atingiu_70", int'(achou), 1);
    verificar("rampa ocupado_antes", int'(cmd.ocupado), 1);
    reset = 1'b0;
    #1;
    verificar("reset_meio ocupado", int'(cmd.ocupado), 0);
    verificar("reset_meio pronto", int'(cmd.pronto), 0);
    verificar("reset_meio pwm", int'(pwm), 0);
    verificar("reset_meio estado", int'(db_estado), 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    verificar("pos_reset largura", int'(db_largura), LARG_REPOU);
    verificar("pos_reset estado", int'(db_estado), 0);
    ocup = 0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clock);
      if (cmd.ocupado !== 1'b0 || int'(db_largura) != LARG_REPOU) ocup++;
    end
    verificar("pos_reset estavel", ocup, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
